// File: rtl/config_loader_pkg.sv
// Shared types and helpers for the serial configuration loader.
//   cl_state_t : loader FSM states
//   ceil_div   : number of input words needed to cover a chain
package config_loader_pkg;

  typedef enum logic [1:0] {
    CL_IDLE,
    CL_LOAD,
    CL_SHIFT,
    CL_DONE
  } cl_state_t;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/config_loader.sv
// config_loader: feeds a serial configuration chain from a parallel word
// stream. Words arrive over valid/ready, are shifted out MSB-first one bit per
// cycle with cfg_en high, and after a full load chain bit i holds target bit i
// (the first bit sent lands in chain bit CHAIN_LEN-1).
//
// Ports
//   cfg_clk  in   config clock, rising edge
//   cfg_rst  in   synchronous active-high reset
//   start    in   begin a load (only honoured in idle)
//   s_valid  in   input word valid
//   s_data   in   input word, bit WORD_W-1 sent first
//   s_ready  out  word accepted on this cycle when s_valid is high
//   cfg_head out  serial data into chain bit 0
//   cfg_en   out  chain shift enable
//   busy     out  load in progress
//   done     out  one-cycle pulse after the last bit has shifted
//
// All outputs are registers; each is updated alongside the state transition
// that makes it true, so none depends combinationally on an input.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              cfg_clk,
  input  logic              cfg_rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              cfg_head,
  output logic              cfg_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned RB = $clog2(CHAIN_LEN + 1);
  localparam int unsigned NB = $clog2(WORD_W + 1);

  cl_state_t         r_state;
  logic [RB-1:0]     r_remaining;
  logic [NB-1:0]     r_nbits;
  logic [WORD_W-1:0] r_sreg;
  logic              r_s_ready;
  logic              r_cfg_head;
  logic              r_cfg_en;
  logic              r_busy;
  logic              r_done;

  logic [WORD_W-1:0] w_sreg_shl;
  logic [NB-1:0]     w_word_bits;

  // A short final word only contributes its top bits: the bit count is
  // clamped to what is still owed to the chain.
  always_comb begin
    w_sreg_shl  = r_sreg << 1;
    w_word_bits = NB'(WORD_W);
    if (32'(r_remaining) < WORD_W) begin
      w_word_bits = NB'(r_remaining);
    end
  end

  always_ff @(posedge cfg_clk) begin
    if (cfg_rst) begin
      r_state     <= CL_IDLE;
      r_remaining <= '0;
      r_nbits     <= '0;
      r_sreg      <= '0;
      r_s_ready   <= 1'b0;
      r_cfg_head  <= 1'b0;
      r_cfg_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        CL_IDLE: begin
          if (start) begin
            r_state     <= CL_LOAD;
            r_remaining <= RB'(CHAIN_LEN);
            r_s_ready   <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        CL_LOAD: begin
          if (s_valid) begin
            r_state    <= CL_SHIFT;
            r_sreg     <= s_data;
            r_nbits    <= w_word_bits;
            r_s_ready  <= 1'b0;
            r_cfg_en   <= 1'b1;
            r_cfg_head <= s_data[WORD_W-1];
          end
        end

        CL_SHIFT: begin
          r_sreg      <= w_sreg_shl;
          r_nbits     <= r_nbits - NB'(1);
          r_remaining <= r_remaining - RB'(1);
          if (r_nbits == NB'(1)) begin
            r_cfg_en   <= 1'b0;
            r_cfg_head <= 1'b0;
            if (r_remaining == RB'(1)) begin
              r_state <= CL_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= CL_LOAD;
              r_s_ready <= 1'b1;
            end
          end else begin
            // Head is registered, so it is loaded with the bit that will be
            // at the top of sreg after this shift.
            r_cfg_head <= w_sreg_shl[WORD_W-1];
          end
        end

        CL_DONE: begin
          r_state <= CL_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state    <= CL_IDLE;
          r_s_ready  <= 1'b0;
          r_cfg_en   <= 1'b0;
          r_cfg_head <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = r_s_ready;
  assign cfg_head = r_cfg_head;
  assign cfg_en   = r_cfg_en;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
